// File: rtl/axi4st_rst_seq_pkg.sv
// Shared types and defaults for the AXI4-ST reset sequencer.
// Combinational-only content; no latency, no backpressure.
package axi4st_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'b00,
    ST_WAIT_LINK = 2'b01,
    ST_HOLD      = 2'b10,
    ST_RUN       = 2'b11
  } seq_state_e;

  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 8;

endpackage

// File: rtl/axi4st_bit_sync.sv
// Single-bit flop-chain synchronizer, STAGES edges of latency, no backpressure.
module axi4st_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/axi4st_rst_seq.sv
// Core reset sequencer: holds core_rst_n low until the link is qualified plus HOLD_CYCLES edges.
// Optional link stability filter enabled by defining AXI4ST_RST_SEQ_LINK_FILTER_EN; no backpressure.
module axi4st_rst_seq
  import axi4st_rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_up,
  input  logic       sw_rst_req,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic [1:0] seq_state
);

  localparam int                CNT_W     = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_param
    $error("axi4st_rst_seq: parameter out of legal range");
  end

  logic             link_s;
  logic             link_q;
  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             core_rst_n_d;
  logic             rst_done_d;

  axi4st_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_link_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (link_up),
    .q     (link_s)
  );

`ifdef AXI4ST_RST_SEQ_LINK_FILTER_EN
  localparam logic [7:0] FLT_MAX = 8'(FILTER_CYCLES);

  logic [7:0] flt_cnt;

  // Saturating count of consecutive high samples; a low sample drops link_q at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
    end else if (!link_s) begin
      flt_cnt <= '0;
    end else if (flt_cnt != FLT_MAX) begin
      flt_cnt <= flt_cnt + 8'd1;
    end
  end

  assign link_q = link_s && (flt_cnt == FLT_MAX);
`else
  assign link_q = link_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      cnt        <= '0;
      core_rst_n <= 1'b0;
      rst_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      core_rst_n <= core_rst_n_d;
      rst_done   <= rst_done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RESET: begin
        state_nxt = ST_WAIT_LINK;
      end
      ST_WAIT_LINK: begin
        if (link_q && !sw_rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        // Link loss outranks a software request; cnt is left untouched on that path.
        if (!link_q) begin
          state_nxt = ST_WAIT_LINK;
        end else if (sw_rst_req) begin
          cnt_nxt = HOLD_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (!link_q) begin
          state_nxt = ST_WAIT_LINK;
        end else if (sw_rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  always_comb begin
    core_rst_n_d = (state_nxt == ST_RUN);
    rst_done_d   = (state_nxt == ST_RUN) && (state != ST_RUN);
  end

  assign seq_state = state;

endmodule
